// File: rtl/branch_resolve_if.sv
// Upstream/downstream signal bundle for the execute-stage branch resolution unit.
// master = issuing stage and consumers; slave = branch_resolve itself.
interface branch_resolve_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        BrUn;
  logic        out_valid;
  logic        BrEq;
  logic        BrLt;
  logic        taken;
  logic        illegal_br;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] link_data;
  logic        flush;

  modport master (
    output in_valid, inst, pc, rs1_data, rs2_data, BrUn,
    input  in_ready, out_valid, BrEq, BrLt, taken, illegal_br,
           redirect_valid, redirect_pc, link_data, flush
  );

  modport slave (
    input  in_valid, inst, pc, rs1_data, rs2_data, BrUn,
    output in_ready, out_valid, BrEq, BrLt, taken, illegal_br,
           redirect_valid, redirect_pc, link_data, flush
  );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: compare, taken decision, redirect target and flush hold.
// Optional feature macro: BRANCH_STATS_EN adds conditional-branch statistics counters.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  branch_resolve_if.slave  bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      br_count,
  output logic [31:0]      br_taken_count
`endif
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        in_ready_r;
  logic        flush_r;
  logic        redirect_valid_r;
  logic        out_valid_r;
  logic        br_eq_r;
  logic        br_lt_r;
  logic        taken_r;
  logic        illegal_r;
  logic [31:0] redirect_pc_r;
  logic [31:0] link_data_r;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_j_s;
  logic [31:0] imm_i_s;
  logic [31:0] pc_plus4_s;
  logic        eq_s;
  logic        lt_s;
  logic        is_branch_s;
  logic        taken_s;
  logic        illegal_s;
  logic [31:0] target_s;
  logic [31:0] next_pc_s;
  logic        accept_s;

  assign opcode_s   = bus.inst[6:0];
  assign funct3_s   = bus.inst[14:12];
  assign imm_b_s    = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7], bus.inst[30:25],
                       bus.inst[11:8], 1'b0};
  assign imm_j_s    = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12], bus.inst[20],
                       bus.inst[30:21], 1'b0};
  assign imm_i_s    = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign pc_plus4_s = bus.pc + 32'd4;
  assign accept_s   = bus.in_valid && in_ready_r && (state_r == ST_IDLE);

  // Operand comparator; BrUn comes from decode and is trusted as-is
  always_comb begin
    eq_s = (bus.rs1_data == bus.rs2_data);
    if (bus.BrUn) begin
      lt_s = (bus.rs1_data < bus.rs2_data);
    end else begin
      lt_s = ($signed(bus.rs1_data) < $signed(bus.rs2_data));
    end
  end

  // Taken decision and redirect target per opcode / funct3
  always_comb begin
    is_branch_s = 1'b0;
    taken_s     = 1'b0;
    illegal_s   = 1'b0;
    target_s    = pc_plus4_s;
    case (opcode_s)
      OP_BRANCH: begin
        is_branch_s = 1'b1;
        target_s    = bus.pc + imm_b_s;
        case (funct3_s)
          3'b000:         taken_s = eq_s;
          3'b001:         taken_s = !eq_s;
          3'b100, 3'b110: taken_s = lt_s;
          3'b101, 3'b111: taken_s = !lt_s;
          default:        illegal_s = 1'b1;
        endcase
      end
      OP_JAL: begin
        taken_s  = 1'b1;
        target_s = bus.pc + imm_j_s;
      end
      OP_JALR: begin
        taken_s  = 1'b1;
        target_s = (bus.rs1_data + imm_i_s) & ~32'd1;
      end
      default: begin
        taken_s  = 1'b0;
        target_s = pc_plus4_s;
      end
    endcase
    if (taken_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Control FSM plus registered result; data outputs hold between accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 4'd0;
      in_ready_r       <= 1'b0;
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      out_valid_r      <= 1'b0;
      br_eq_r          <= 1'b0;
      br_lt_r          <= 1'b0;
      taken_r          <= 1'b0;
      illegal_r        <= 1'b0;
      redirect_pc_r    <= 32'd0;
      link_data_r      <= 32'd0;
    end else begin
      out_valid_r      <= accept_s;
      redirect_valid_r <= accept_s && taken_s;
      if (accept_s) begin
        br_eq_r       <= eq_s;
        br_lt_r       <= lt_s;
        taken_r       <= taken_s;
        illegal_r     <= illegal_s;
        redirect_pc_r <= next_pc_s;
        link_data_r   <= pc_plus4_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s && taken_s) begin
            state_r    <= ST_FLUSH;
            cnt_r      <= FLUSH_LOAD;
            in_ready_r <= 1'b0;
            flush_r    <= 1'b1;
          end else begin
            in_ready_r <= 1'b1;
            flush_r    <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // cnt_r equals the remaining flush cycles including the current one
          if (cnt_r <= 4'd1) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            in_ready_r <= 1'b1;
            flush_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= 4'd0;
          in_ready_r <= 1'b0;
          flush_r    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_r;
  logic [31:0] br_taken_count_r;

  // Saturating conditional-branch counters, updated with the result register
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_r       <= 32'd0;
      br_taken_count_r <= 32'd0;
    end else if (accept_s && is_branch_s) begin
      if (br_count_r != 32'hFFFF_FFFF) begin
        br_count_r <= br_count_r + 32'd1;
      end
      if (taken_s && (br_taken_count_r != 32'hFFFF_FFFF)) begin
        br_taken_count_r <= br_taken_count_r + 32'd1;
      end
    end
  end

  assign br_count       = br_count_r;
  assign br_taken_count = br_taken_count_r;
`endif

  assign bus.in_ready       = in_ready_r;
  assign bus.out_valid      = out_valid_r;
  assign bus.BrEq           = br_eq_r;
  assign bus.BrLt           = br_lt_r;
  assign bus.taken          = taken_r;
  assign bus.illegal_br     = illegal_r;
  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;
  assign bus.link_data      = link_data_r;
  assign bus.flush          = flush_r;

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit. Consumes the decoded BrUn signal together with the instruction, PC and register operands. It registers the branch comparison (BrEq/BrLt), decides taken/not-taken for conditional branches, JAL and JALR, and computes the redirect target and link value. On a taken control transfer it issues a one-cycle redirect to fetch and holds a flush of the younger pipeline stages for a programmable number of cycles, back-pressuring its input meanwhile.

## Interface
Parameters:
- FLUSH_CYCLES, 2, cycles `flush` is held after a taken transfer. Legal range 1–15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  inst/pc/operands valid this cycle
- in_ready  out  1  stage can accept; transfer on `in_valid && in_ready`
- inst  in  32  instruction word
- pc  in  32  instruction PC
- rs1_data  in  32  rs1 operand
- rs2_data  in  32  rs2 operand
- BrUn  in  1  1 = unsigned compare, 0 = signed
- out_valid  out  1  registered result valid; one-cycle pulse per accepted instruction
- BrEq  out  1  registered rs1 == rs2
- BrLt  out  1  registered rs1 < rs2, with signedness set by BrUn
- taken  out  1  control transfer taken
- illegal_br  out  1  branch opcode with funct3 010/011
- redirect_valid  out  1  one-cycle redirect request to fetch
- redirect_pc  out  32  redirect target
- link_data  out  32  pc+4 (JAL/JALR writeback value)
- flush  out  1  kill younger stages

## Operation
- Opcodes: 1100011 = branch; 1101111 = JAL; 1100111 = JALR. All other opcodes are not taken, with redirect_pc = pc+4.
- Comparator: BrEq = (rs1==rs2). BrLt uses an unsigned compare when BrUn=1 and a signed compare otherwise. BrUn is used as given; it is not re-derived from funct3.
- Branch taken by funct3:
  - 000: BrEq
  - 001: !BrEq
  - 100/110: BrLt
  - 101/111: !BrLt
  - 010/011: not taken, illegal_br=1
- JAL and JALR are always taken.
- Immediates are sign-extended to 32 bits. All adds are 32-bit and wrap modulo 2^32.
  - Branch target: pc+immB (inst[31],inst[7],inst[30:25],inst[11:8],0).
  - JAL target: pc+immJ.
  - JALR target: (rs1+immI) & ~1.
  - redirect_pc carries the target when taken, otherwise pc+4.
- State machine:
  - IDLE: in_ready=1. On an accept with taken result → FLUSH, counter loaded with FLUSH_CYCLES.
  - FLUSH: in_ready=0, flush=1, counter decrements each cycle. At count 1 → IDLE.
- Input arriving while in_ready=0 is ignored. Upstream holds it.

## Timing
- Accept at edge N → out_valid, BrEq, BrLt, taken, illegal_br, redirect_pc and link_data are valid during cycle N+1 (latency 1).
- Not taken: in_ready stays 1. Back-to-back accepts give throughput of 1 per cycle.
- Taken:
  - redirect_valid=1 in cycle N+1 only.
  - flush=1 in cycles N+1 … N+FLUSH_CYCLES.
  - in_ready=0 over the same window; in_ready=1 again at N+FLUSH_CYCLES+1.
- Data outputs hold their last value when out_valid=0.
- Reset:
  - All outputs are 0, including in_ready, while rst=1. State is IDLE.
  - in_ready=1 in the first cycle after rst deasserts.
- Reset during FLUSH aborts the flush; flush and redirect_valid are 0 from the following cycle.
- rst has priority over a simultaneous accept; the instruction is dropped.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds output ports br_count[31:0] and br_taken_count[31:0].
  - Both counters increment on the cycle out_valid=1 for a conditional-branch opcode. br_taken_count increments only when that branch is taken.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- BRANCH_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Signed BLT: funct3=100, BrUn=0, rs1=0xFFFFFFFF, rs2=1, pc=0x100, immB=+16 → cycle N+1: BrLt=1, taken=1, redirect_valid=1, redirect_pc=0x110. flush high for 2 cycles; in_ready low for 2 cycles.
- Unsigned BLTU: funct3=110, BrUn=1, same operands → BrLt=0, taken=0, redirect_pc=0x104, flush=0. A second instruction accepted in cycle N+1.
- JALR: rs1=0x2001, immI=+2, pc=0x40 → redirect_pc=0x2002 (bit0 cleared), link_data=0x44, taken=1.
- Illegal funct3=010 on a branch → illegal_br=1, taken=0, no flush.
- rst asserted in the first FLUSH cycle → flush=0 and in_ready=0 the next cycle; in_ready=1 one cycle after rst deasserts.
- BRANCH_STATS_EN: 3 BEQ (2 equal) plus 1 JAL → br_count=3, br_taken_count=2.
